// File: rtl/expr_eval.sv
// Streaming ASCII expression recognizer/evaluator: multi-digit operands with +, -, * ('*' binds tighter).
// Define EXPR_EVAL_EN to build the evaluation datapath; otherwise value is tied to 0.
module expr_eval #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned MAX_DIGITS = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [7:0]       in,
  input  logic             in_valid,
  output logic             out,
  output logic             err,
  output logic [WIDTH-1:0] value
);

  localparam int unsigned CW = $clog2(MAX_DIGITS + 1);

  typedef enum logic [1:0] {S_IDLE, S_NUM, S_OP, S_ERR} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   dcnt_q, dcnt_d;
  logic            out_q, err_q;
  logic            is_digit, is_op;

  assign is_digit = (in >= 8'h30) && (in <= 8'h39);
  assign is_op    = (in == 8'h2B) || (in == 8'h2D) || (in == 8'h2A);

  // Recognizer: next state and digit count.
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    if (in_valid) begin
      case (state_q)
        S_IDLE, S_OP: begin
          if (is_digit) begin
            state_d = S_NUM;
            dcnt_d  = CW'(1);
          end else begin
            state_d = S_ERR;
          end
        end
        S_NUM: begin
          if (is_digit) begin
            if (dcnt_q == CW'(MAX_DIGITS)) begin
              state_d = S_ERR;
            end else begin
              dcnt_d = dcnt_q + CW'(1);
            end
          end else if (is_op) begin
            state_d = S_OP;
            dcnt_d  = '0;
          end else begin
            state_d = S_ERR;
          end
        end
        default: state_d = S_ERR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      dcnt_q  <= '0;
      out_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      out_q   <= (state_d == S_NUM);
      err_q   <= (state_d == S_ERR);
    end
  end

  assign out = out_q;
  assign err = err_q;

`ifdef EXPR_EVAL_EN
  logic [WIDTH-1:0] sum_q, sum_d, prod_q, prod_d, num_q, num_d, value_q, value_d;
  logic [WIDTH-1:0] mul_pn, term_d;
  logic             neg_q, neg_d, upd;

  // Registers freeze on the edge that enters ERR and afterwards.
  assign upd = in_valid && (state_d != S_ERR);

  always_comb begin
    sum_d  = sum_q;
    prod_d = prod_q;
    num_d  = num_q;
    neg_d  = neg_q;
    mul_pn = prod_q * num_q;
    if (is_digit) begin
      num_d = num_q * WIDTH'(10) + WIDTH'(in[3:0]);
    end else if (in == 8'h2A) begin
      prod_d = mul_pn;
      num_d  = '0;
    end else begin
      sum_d  = neg_q ? (sum_q - mul_pn) : (sum_q + mul_pn);
      prod_d = WIDTH'(1);
      num_d  = '0;
      neg_d  = (in == 8'h2D);
    end
    term_d  = prod_d * num_d;
    value_d = neg_d ? (sum_d - term_d) : (sum_d + term_d);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sum_q   <= '0;
      prod_q  <= WIDTH'(1);
      num_q   <= '0;
      neg_q   <= 1'b0;
      value_q <= '0;
    end else if (upd) begin
      sum_q   <= sum_d;
      prod_q  <= prod_d;
      num_q   <= num_d;
      neg_q   <= neg_d;
      value_q <= value_d;
    end
  end

  assign value = value_q;
`else
  assign value = '0;
`endif

endmodule

// File: tb/tb_expr_eval.sv
// Scoreboard bench for expr_eval (WIDTH=16, MAX_DIGITS=4); value expectations follow EXPR_EVAL_EN.
module tb_expr_eval;

  logic        clk = 1'b0;
  logic        clr;
  logic [7:0]  in;
  logic        in_valid;
  logic        out, err;
  logic [15:0] value;

  typedef struct packed {
    logic        eo;
    logic        ee;
    logic        cv;
    logic [15:0] ev;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  expr_eval #(.WIDTH(16), .MAX_DIGITS(4)) u_dut (
    .clk(clk), .clr(clr), .in(in), .in_valid(in_valid),
    .out(out), .err(err), .value(value)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Pop one expectation and compare it with the current DUT outputs.
  task automatic compare(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({tag, ".queue"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, ".out"}, 32'(out), 32'(e.eo));
    check({tag, ".err"}, 32'(err), 32'(e.ee));
    if (e.cv) begin
`ifdef EXPR_EVAL_EN
      check({tag, ".value"}, 32'(value), 32'(e.ev));
`else
      check({tag, ".value"}, 32'(value), 32'd0);
`endif
    end
  endtask

  task automatic send(input byte c, input logic eo, input logic ee,
                      input logic cv, input logic [15:0] ev, input string tag);
    @(negedge clk);
    in       = c;
    in_valid = 1'b1;
    exp_q.push_back('{eo, ee, cv, ev});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    compare(tag);
  endtask

  // Idle cycles with a garbage character on the bus: outputs must hold.
  task automatic gap(input int n, input logic eo, input logic ee,
                     input logic cv, input logic [15:0] ev, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in       = 8'h2B;
      in_valid = 1'b0;
      exp_q.push_back('{eo, ee, cv, ev});
      @(posedge clk);
      #1;
      compare(tag);
    end
  endtask

  // Mid-cycle clear: outputs drop at once, and an edge under clr is ignored.
  task automatic clr_pulse(input string tag);
    @(negedge clk);
    #2;
    clr = 1'b1;
    #1;
    exp_q.push_back('{1'b0, 1'b0, 1'b1, 16'h0000});
    compare({tag, ".imm"});
    in       = 8'h39;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back('{1'b0, 1'b0, 1'b1, 16'h0000});
    compare({tag, ".held"});
    @(negedge clk);
    in_valid = 1'b0;
    clr      = 1'b0;
  endtask

  initial begin
    clr      = 1'b1;
    in       = 8'h00;
    in_valid = 1'b0;
    #1;
    exp_q.push_back('{1'b0, 1'b0, 1'b1, 16'h0000});
    compare("reset");
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;

    // 1+2+1*1
    send("1", 1, 0, 1, 16'd1, "a1");
    send("+", 0, 0, 0, 16'd0, "a2");
    send("2", 1, 0, 1, 16'd3, "a3");
    send("+", 0, 0, 0, 16'd0, "a4");
    send("1", 1, 0, 1, 16'd4, "a5");
    send("*", 0, 0, 0, 16'd0, "a6");
    send("1", 1, 0, 1, 16'd4, "a7");
    clr_pulse("clrA");

    // 12*3-4 = 32
    send("1", 1, 0, 1, 16'd1,  "b1");
    send("2", 1, 0, 1, 16'd12, "b2");
    send("*", 0, 0, 0, 16'd0,  "b3");
    send("3", 1, 0, 1, 16'd36, "b4");
    send("-", 0, 0, 0, 16'd0,  "b5");
    send("4", 1, 0, 1, 16'd32, "b6");
    clr_pulse("clrB");

    // 5-7 wraps to 0xFFFE
    send("5", 1, 0, 1, 16'd5,    "c1");
    send("-", 0, 0, 0, 16'd0,    "c2");
    send("7", 1, 0, 1, 16'hFFFE, "c3");
    clr_pulse("clrC");

    // 1++ is sticky error
    send("1", 1, 0, 1, 16'd1, "d1");
    send("+", 0, 0, 0, 16'd0, "d2");
    send("+", 0, 1, 0, 16'd0, "d3");
    send("5", 0, 1, 0, 16'd0, "d4");
    gap(2, 0, 1, 0, 16'd0, "d5");
    clr_pulse("clrD");

    // Illegal character and leading operator
    send("7", 1, 0, 1, 16'd7, "e1");
    send("a", 0, 1, 0, 16'd0, "e2");
    clr_pulse("clrE");
    send("*", 0, 1, 0, 16'd0, "e3");
    send("3", 0, 1, 0, 16'd0, "e4");
    clr_pulse("clrF");

    // Digit limit: fifth digit errors, value holds 1234
    send("1", 1, 0, 1, 16'd1,    "f1");
    send("2", 1, 0, 1, 16'd12,   "f2");
    send("3", 1, 0, 1, 16'd123,  "f3");
    send("4", 1, 0, 1, 16'd1234, "f4");
    send("5", 0, 1, 1, 16'd1234, "f5");
    clr_pulse("clrG");

    // Leading zeros count toward the limit
    send("0", 1, 0, 1, 16'd0, "g1");
    send("0", 1, 0, 1, 16'd0, "g2");
    send("0", 1, 0, 1, 16'd0, "g3");
    send("0", 1, 0, 1, 16'd0, "g4");
    send("1", 0, 1, 1, 16'd0, "g5");
    clr_pulse("clrH");

    // Counter resets on operator; gaps do not disturb the result
    send("1", 1, 0, 1, 16'd1,    "h1");
    send("2", 1, 0, 1, 16'd12,   "h2");
    send("3", 1, 0, 1, 16'd123,  "h3");
    send("4", 1, 0, 1, 16'd1234, "h4");
    gap(3, 1, 0, 1, 16'd1234,    "h4g");
    send("+", 0, 0, 0, 16'd0,    "h5");
    send("5", 1, 0, 1, 16'd1239, "h6");
    send("6", 1, 0, 1, 16'd1290, "h7");
    gap(1, 1, 0, 1, 16'd1290,    "h7g");
    send("7", 1, 0, 1, 16'd1801, "h8");
    send("8", 1, 0, 1, 16'd6912, "h9");
    clr_pulse("clrI");

    // 300*300 = 90000 mod 65536 = 24464
    send("3", 1, 0, 1, 16'd3,     "i1");
    send("0", 1, 0, 1, 16'd30,    "i2");
    send("0", 1, 0, 1, 16'd300,   "i3");
    send("*", 0, 0, 0, 16'd0,     "i4");
    gap(2, 0, 0, 0, 16'd0,        "i4g");
    send("3", 1, 0, 1, 16'd900,   "i5");
    send("0", 1, 0, 1, 16'd9000,  "i6");
    send("0", 1, 0, 1, 16'd24464, "i7");
    clr_pulse("clrJ");

    // 1* then clear, then 1*1
    send("1", 1, 0, 1, 16'd1, "j1");
    send("*", 0, 0, 0, 16'd0, "j2");
    clr_pulse("clrK");
    send("1", 1, 0, 1, 16'd1, "j3");
    send("*", 0, 0, 0, 16'd0, "j4");
    send("1", 1, 0, 1, 16'd1, "j5");

    if (exp_q.size() != 0) check("queue.drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/expr_eval.md
# expr_eval

Streaming ASCII arithmetic-expression recognizer and evaluator. It is the parametrised successor of the single-digit `string` recognizer and accepts multi-digit decimal operands joined by `+`, `-` and `*`. One character is consumed per enabled clock. The block continuously reports whether the prefix received so far is a complete, valid expression and, when evaluation is compiled in, that expression's value with `*` binding tighter than `+`/`-`. It sits behind a UART/keyboard byte stream in the P1 calculator path.

## Interface
Parameters:
- `WIDTH`, 16: width of the result and of all internal arithmetic registers (≥4).
- `MAX_DIGITS`, 4: maximum digits per operand (≥1). Leading zeros count toward the limit.

Ports:
- `clk`  in  1  — single clock, rising-edge active.
- `clr`  in  1  — reset, asynchronous, active-high.
- `in`  in  8  — ASCII character.
- `in_valid`  in  1  — `in` is consumed on a rising edge only when this is 1.
- `out`  out  1  — prefix received so far is a complete valid expression.
- `err`  out  1  — sticky syntax error.
- `value`  out  WIDTH  — value of the prefix; meaningful only while `out`=1.

## Operation
- Character classes:
  - DIGIT: `"0"`–`"9"` (0x30–0x39).
  - OP: `+`, `-`, `*`.
  - Anything else is ILLEGAL.
- FSM states: IDLE, NUM, OP, ERR. Reset state is IDLE.
  - IDLE: DIGIT → NUM. OP or ILLEGAL → ERR.
  - NUM: DIGIT → NUM, unless the digit count would exceed `MAX_DIGITS`, in which case → ERR. OP → OP. ILLEGAL → ERR.
  - OP: DIGIT → NUM. OP or ILLEGAL → ERR.
  - ERR: absorbing; only `clr` leaves it.
- `out` = (state == NUM). `err` = (state == ERR).
- Evaluation registers, all WIDTH bits, modulo 2^WIDTH:
  - `sum`: completed terms.
  - `prod`: completed factors of the current term, initialised to 1.
  - `num`: current operand.
  - `neg`: sign of the current term.
- Register updates:
  - DIGIT: num ← num·10 + d.
  - `*`: prod ← prod·num; num ← 0.
  - `+` / `-`: sum ← sum ± prod·num, using the current `neg`; prod ← 1; num ← 0; neg ← (char == `-`).
- `value` is registered and equals sum ± prod·num computed from the next-state registers. It updates on every consumed character.
- The only negation is unary on a term. The result is two's-complement wrap; there is no overflow flag.
- Once in ERR, evaluation registers freeze and `value` holds.

## Timing
- Latency: a character consumed at edge k is reflected in `out`, `err` and `value` immediately after edge k, i.e. one registered stage.
- `in_valid`=0: no state or register change; outputs hold.
- `clr` asserted at any time, including mid-cycle or mid-expression:
  - Outputs go immediately to `out`=0, `err`=0, `value`=0.
  - State goes to IDLE with sum=0, prod=1, num=0, neg=0.
  - While `clr` is high, edges are ignored.
  - The first character is consumed on the first rising edge after `clr` deasserts.
- Digit counter: resets on each OP. The (`MAX_DIGITS`+1)th consecutive digit forces ERR on that edge.

## Configuration
- `EXPR_EVAL_EN` defined: evaluation registers and multipliers are built, and `value` behaves as specified.
- `EXPR_EVAL_EN` undefined:
  - Only the FSM and digit counter are built.
  - `value` is tied to 0.
  - `out` and `err` behaviour is identical to the defined case.

## Test plan
- Reset then `"1","+","2","+","1","*","1"`, one per cycle, `in_valid`=1 → `out` sequence 1,0,1,0,1,0,1; final `value`=4; `err`=0.
- `"1","2","*","3","-","4"` → final `out`=1, `value`=32. `"5","-","7"` with WIDTH=16 → `value`=0xFFFE.
- `"1","+","+"` → `err`=1 after the third edge; further digits leave `out`=0 and `err`=1 until `clr`.
- MAX_DIGITS=3, `"1","2","3","4"` → `out`=1 after three edges; `err`=1 on the fourth; `value` holds 123.
- WIDTH=8, `"2","0","0","*","2"` → `value`=144 (400 mod 256). `in_valid`=0 gaps between characters give the same result.
- `"1","*"` then `clr` pulse mid-cycle → outputs 0 immediately. Then `"1","*","1"` → `value`=1, `out`=1. Rebuilt without `EXPR_EVAL_EN` → same `out`/`err` trace, `value`=0 throughout.
